// File: rtl/keyexpand_seq.sv
// keyexpand_seq: iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready handshake.
// Optional KEYEXP_INV_EN adds an inv input that walks the schedule backwards from round key 10.
module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] y, r;
    // GF(2^8) inverse as x^254; zero maps to zero naturally
    always_comb begin
        y = a_i;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            y = gmul(y, y);
            r = gmul(r, y);
        end
        s_o = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
endmodule

module keyexpand_seq #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
`ifdef KEYEXP_INV_EN
    input  logic         inv,
`endif
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [127:0]  rk_q, rk_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          valid_q, valid_d;
    logic          inv_q, inv_d;
    logic          inv_in;

`ifdef KEYEXP_INV_EN
    assign inv_in = inv;
`else
    assign inv_in = 1'b0;
`endif

    logic [31:0] w0, w1, w2, w3, sub_in, rot, sub, t;
    logic [127:0] next_rk;
    logic [7:0]  next_rcon;
    logic        last;

    assign {w0, w1, w2, w3} = rk_q;
    // inverse step recovers the previous w3 as w3^w2 before applying SubWord(RotWord())
    assign sub_in = inv_q ? (w3 ^ w2) : w3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (.a_i(rot[8*g +: 8]), .s_o(sub[8*g +: 8]));
    end

    assign t = sub ^ {rcon_q, 24'h0};
    assign next_rk = inv_q ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2}
                           : {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    assign next_rcon = inv_q ? (rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80) : (rcon_q >> 1))
                             : ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00));
    assign last = inv_q ? (idx_q == 4'd0) : (idx_q == 4'(NROUNDS));

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = EMIT;
                rk_d    = key;
                idx_d   = inv_in ? 4'(NROUNDS) : 4'd0;
                rcon_d  = inv_in ? 8'h36 : 8'h01;
                valid_d = 1'b1;
                inv_d   = inv_in;
            end
            EMIT: if (valid_q && rk_ready) begin
                if (last) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end else begin
                    rk_d   = next_rk;
                    idx_d  = inv_q ? idx_q - 4'd1 : idx_q + 4'd1;
                    rcon_d = next_rcon;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            inv_q   <= inv_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign rk_valid = valid_q;
    assign rk       = rk_q;
    assign rk_idx   = idx_q;
endmodule
